// File: rtl/cbx_param_shadow_if.sv
// cbx_param_shadow_if: channel, config-chain and grid-pin signals of one connection block
interface cbx_param_shadow_if #(
  parameter int CHAN_WIDTH = 16,
  parameter int NUM_IPIN = 8
);
  logic [CHAN_WIDTH-1:0] chanx_left_in;
  logic [CHAN_WIDTH-1:0] chanx_right_in;
  logic [CHAN_WIDTH-1:0] chanx_left_out;
  logic [CHAN_WIDTH-1:0] chanx_right_out;
  logic ccff_head;
  logic ccff_en;
  logic cfg_commit;
  logic ccff_tail;
  logic cfg_full;
  logic cfg_active;
  logic [NUM_IPIN-1:0] ipin_out;
  modport master (
    output chanx_left_in, chanx_right_in, ccff_head, ccff_en, cfg_commit,
    input chanx_left_out, chanx_right_out, ccff_tail, cfg_full, cfg_active, ipin_out
  );
  modport slave (
    input chanx_left_in, chanx_right_in, ccff_head, ccff_en, cfg_commit,
    output chanx_left_out, chanx_right_out, ccff_tail, cfg_full, cfg_active, ipin_out
  );
endinterface

// File: rtl/cbx_param_shadow.sv
// cbx_param_shadow: X connection block with shadowed ccff config chain driving ipin muxes
module cbx_param_shadow #(
  parameter int CHAN_WIDTH = 16,
  parameter int NUM_IPIN = 8,
  parameter int MUX_SIZE = 10,
  parameter int SEL_BITS = $clog2(MUX_SIZE),
  parameter int TRACK_STRIDE = 2,
  parameter int OUT_REG = 1,
  parameter int CFG_BITS = NUM_IPIN * SEL_BITS
) (
  input logic prog_clk,
  input logic prog_reset,
  cbx_param_shadow_if.slave bus
);
  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CFG_BITS);
  localparam int MW = 1 << SEL_BITS;
  logic [CFG_BITS-1:0] chain;
  logic [CFG_BITS-1:0] shadow;
  logic [CW-1:0] bit_cnt;
  logic cfg_active;
  logic [MW-1:0] mux_in [NUM_IPIN];
  logic [NUM_IPIN-1:0] ipin_nxt;
  assign bus.chanx_left_out = bus.chanx_right_in;
  assign bus.chanx_right_out = bus.chanx_left_in;
  assign bus.ccff_tail = chain[CFG_BITS-1];
  assign bus.cfg_full = bit_cnt == FULL;
  assign bus.cfg_active = cfg_active;
  // Mux inputs padded to a power of two; out-of-range selects hit constant 0 so every code decodes
  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
    for (genvar j = 0; j < MW; j++) begin : g_in
      localparam int T = (k + (j / 2) * TRACK_STRIDE) % CHAN_WIDTH;
      if (j >= MUX_SIZE) begin : g_park
        assign mux_in[k][j] = 1'b0;
      end else if (j % 2 == 0) begin : g_left
        assign mux_in[k][j] = bus.chanx_left_in[T];
      end else begin : g_right
        assign mux_in[k][j] = bus.chanx_right_in[T];
      end
    end
  end
  // Config chain shift, shadow commit and saturating shift counter; commit copies the pre-shift chain
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain <= '0;
      shadow <= '0;
      bit_cnt <= '0;
      cfg_active <= 1'b0;
    end else begin
      if (bus.ccff_en) chain <= CFG_BITS'({chain, bus.ccff_head});
      if (bus.cfg_commit) begin
        shadow <= chain;
        cfg_active <= 1'b1;
      end
      bit_cnt <= bus.cfg_commit ? CW'(bus.ccff_en) :
                 (bus.ccff_en && bit_cnt != FULL) ? bit_cnt + CW'(1) : bit_cnt;
    end
  end
  // Select each pin's track from the active (shadow) field only
  always_comb begin
    ipin_nxt = '0;
    for (int k = 0; k < NUM_IPIN; k++)
      ipin_nxt[k] = cfg_active & mux_in[k][shadow[k*SEL_BITS +: SEL_BITS]];
  end
  if (OUT_REG != 0) begin : g_reg
    logic [NUM_IPIN-1:0] ipin_q;
    // Registered pin drive, one cycle behind inputs and shadow
    always_ff @(posedge prog_clk) ipin_q <= prog_reset ? '0 : ipin_nxt;
    assign bus.ipin_out = ipin_q;
  end else begin : g_comb
    assign bus.ipin_out = ipin_nxt;
  end
endmodule
